axi_slave_mem: RTL and testbench

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

---
 rtl/axi_pkg.sv | 37 +++
 rtl/axi_slave_mem_if.sv | 44 ++++
 rtl/axi_mem_array.sv | 29 ++
 rtl/axi_slave_mem.sv | 150 +++++++++++++++
 tb/tb_axi_slave_mem.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes, FSM state encodings and the
// address-decode helper used by both the write and read paths.
package axi_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ID_W   = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

  // True when addr is word aligned and falls inside the mapped window.
  // Subtraction wraps modulo 2^32, so addresses below base decode as misses.
  function automatic logic word_hit(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input int unsigned       words);
    logic [ADDR_W-1:0] off;
    off = addr - base;
    return (addr[1:0] == 2'b00) && (off < (words * 4));
  endfunction

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI channel bundle between a master and the slave memory.
interface axi_slave_mem_if;

  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] AWADDR;
  logic [3:0]  AWID;

  logic        WVALID;
  logic        WREADY;
  logic [31:0] WDATA;
  logic        WLAST;

  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic [3:0]  BID;

  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] ARADDR;
  logic [3:0]  ARID;

  logic        RVALID;
  logic        RREADY;
  logic [31:0] RDATA;
  logic        RLAST;
  logic [3:0]  RID;

  modport slave (
    input  AWVALID, AWADDR, AWID, WVALID, WDATA, WLAST, BREADY,
           ARVALID, ARADDR, ARID, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, BID,
           ARREADY, RVALID, RDATA, RLAST, RID
  );

  modport master (
    output AWVALID, AWADDR, AWID, WVALID, WDATA, WLAST, BREADY,
           ARVALID, ARADDR, ARID, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, BID,
           ARREADY, RVALID, RDATA, RLAST, RID
  );

endinterface

// File: rtl/axi_mem_array.sv
// Word storage: one synchronous write port, one combinational read port,
// asynchronously cleared on reset.
module axi_mem_array #(
  parameter int unsigned WORDS = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [WORDS];

  // Clear every word on reset, otherwise commit a write on the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/axi_slave_mem.sv
// AXI slave backed by a small word memory; independent write and read FSMs.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 16,
  parameter int unsigned RD_LEN    = 4
) (
  input logic             ACLK,
  input logic             ARESETn,
  axi_slave_mem_if.slave  bus
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  wstate_t     w_state, w_next;
  rstate_t     r_state, r_next;
  logic        live;
  logic [31:0] w_addr, r_addr, w_off, r_off;
  logic [3:0]  w_id, r_id, r_beat;
  logic        w_slverr, w_decerr;
  logic        r_hold;
  logic [31:0] r_hold_data, rd_word, rdata_live;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        w_hit, r_hit;
  resp_t       w_resp;

  assign w_off = w_addr - BASE_ADDR;
  assign r_off = r_addr - BASE_ADDR;
  assign w_hit = word_hit(w_addr, BASE_ADDR, MEM_WORDS);
  assign r_hit = word_hit(r_addr, BASE_ADDR, MEM_WORDS);

  assign aw_hs = bus.AWVALID && live && (w_state == W_IDLE);
  assign w_hs  = bus.WVALID && (w_state == W_DATA);
  assign b_hs  = bus.BREADY && (w_state == W_RESP);
  assign ar_hs = bus.ARVALID && live && (r_state == R_IDLE);
  assign r_hs  = bus.RREADY && (r_state == R_DATA);

  axi_mem_array #(
    .WORDS (MEM_WORDS),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .we      (w_hs && w_hit),
    .wr_idx  (IDX_W'(w_off >> 2)),
    .wr_data (bus.WDATA),
    .rd_idx  (IDX_W'(r_off >> 2)),
    .rd_data (rd_word)
  );

  // Holds the address-ready outputs low until the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) live <= 1'b0;
    else          live <= 1'b1;
  end

  // Write and read state registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Write FSM next state.
  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && bus.WLAST) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Read FSM next state.
  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && bus.RLAST) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Write burst context: captured address/id, per-beat address, error flags.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_addr   <= '0;
      w_id     <= '0;
      w_slverr <= 1'b0;
      w_decerr <= 1'b0;
    end else if (aw_hs) begin
      w_addr   <= bus.AWADDR;
      w_id     <= bus.AWID;
      w_slverr <= (bus.AWADDR[1:0] != 2'b00);
      w_decerr <= 1'b0;
    end else if (w_hs) begin
      w_addr <= w_addr + 32'd4;
      if (!w_hit) w_decerr <= 1'b1;
    end
  end

  // Read burst context. The first cycle of a beat shows memory directly; if
  // the beat stalls, that value is frozen so a concurrent write cannot
  // change data already on the bus.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_addr      <= '0;
      r_id        <= '0;
      r_beat      <= '0;
      r_hold      <= 1'b0;
      r_hold_data <= '0;
    end else if (ar_hs) begin
      r_addr <= bus.ARADDR;
      r_id   <= bus.ARID;
      r_beat <= '0;
      r_hold <= 1'b0;
    end else if (r_state == R_DATA) begin
      if (bus.RREADY) begin
        r_addr <= r_addr + 32'd4;
        r_beat <= r_beat + 4'd1;
        r_hold <= 1'b0;
      end else if (!r_hold) begin
        r_hold      <= 1'b1;
        r_hold_data <= rdata_live;
      end
    end
  end

  assign w_resp     = w_slverr ? SLVERR : (w_decerr ? DECERR : OKAY);
  assign rdata_live = r_hit ? rd_word : '0;

  assign bus.AWREADY = live && (w_state == W_IDLE);
  assign bus.WREADY  = (w_state == W_DATA);
  assign bus.BVALID  = (w_state == W_RESP);
  assign bus.BRESP   = (w_state == W_RESP) ? w_resp : OKAY;
  assign bus.BID     = (w_state == W_RESP) ? w_id : '0;

  assign bus.ARREADY = live && (r_state == R_IDLE);
  assign bus.RVALID  = (r_state == R_DATA);
  assign bus.RDATA   = (r_state != R_DATA) ? '0 : (r_hold ? r_hold_data : rdata_live);
  assign bus.RLAST   = (r_state == R_DATA) && (r_beat == 4'(RD_LEN - 1));
  assign bus.RID     = (r_state == R_DATA) ? r_id : '0;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: stimulus pushes expected B/R beats,
// a negedge monitor pops and compares on every handshake.
module tb_axi_slave_mem;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  logic ACLK;
  logic ARESETn;

  axi_slave_mem_if bus ();

  axi_slave_mem #(
    .BASE_ADDR (32'h0000_0000),
    .MEM_WORDS (16),
    .RD_LEN    (4)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int unsigned vectors;
  int unsigned errors;
  rbeat_t      exp_r[$];
  bexp_t       exp_b[$];
  logic [31:0] wbeats [16];
  logic [31:0] rexp   [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int unsigned got, input int unsigned want);
    vectors++;
    errors++;
    $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  // Scoreboard consumer plus a stall-stability check on the R channel.
  task automatic monitor();
    logic        stalled = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic [3:0]  prev_id = '0;
    bexp_t       eb;
    rbeat_t      er;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        stalled = 1'b0;
      end else begin
        if (bus.BVALID && bus.BREADY) begin
          if (exp_b.size() == 0) fail_now("b_unexpected", 1, 0);
          else begin
            eb = exp_b.pop_front();
            check("bresp", bus.BRESP, eb.resp);
            check("bid", bus.BID, eb.id);
          end
        end
        if (stalled && bus.RVALID) begin
          check("r_stall_data", bus.RDATA, prev_data);
          check("r_stall_last", bus.RLAST, prev_last);
          check("r_stall_id", bus.RID, prev_id);
        end
        if (bus.RVALID && bus.RREADY) begin
          if (exp_r.size() == 0) fail_now("r_unexpected", 1, 0);
          else begin
            er = exp_r.pop_front();
            check("rdata", bus.RDATA, er.data);
            check("rlast", bus.RLAST, er.last);
            check("rid", bus.RID, er.id);
          end
        end
        stalled   = bus.RVALID && !bus.RREADY;
        prev_data = bus.RDATA;
        prev_last = bus.RLAST;
        prev_id   = bus.RID;
      end
    end
  endtask

  task automatic wait_ready(input int unsigned ch, input string name);
    logic rdy;
    for (int unsigned i = 0; i < 64; i++) begin
      @(negedge ACLK);
      rdy = (ch == 0) ? bus.AWREADY : ((ch == 1) ? bus.WREADY : bus.ARREADY);
      @(posedge ACLK); #1;
      if (rdy) return;
    end
    fail_now({name, "_timeout"}, 0, 1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id,
                          input int unsigned n, input logic [1:0] resp);
    exp_b.push_back('{resp: resp, id: id});
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b1; bus.AWADDR = addr; bus.AWID = id;
    wait_ready(0, "aw");
    bus.AWVALID = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      bus.WVALID = 1'b1; bus.WDATA = wbeats[i]; bus.WLAST = (i == n - 1);
      wait_ready(1, "w");
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
  endtask

  task automatic push_read(input logic [3:0] id);
    for (int unsigned i = 0; i < 4; i++)
      exp_r.push_back('{data: rexp[i], last: (i == 3), id: id});
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id);
    push_read(id);
    @(posedge ACLK); #1;
    bus.ARVALID = 1'b1; bus.ARADDR = addr; bus.ARID = id;
    wait_ready(2, "ar");
    bus.ARVALID = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int unsigned i = 0; i < 200; i++) begin
      if (exp_r.size() == 0 && exp_b.size() == 0) break;
      @(posedge ACLK); #1;
    end
    check({name, "_pending"}, exp_r.size() + exp_b.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, bus.AWREADY, 0);
    check({tag, "_wready"},  bus.WREADY,  0);
    check({tag, "_bvalid"},  bus.BVALID,  0);
    check({tag, "_bresp"},   bus.BRESP,   0);
    check({tag, "_bid"},     bus.BID,     0);
    check({tag, "_arready"}, bus.ARREADY, 0);
    check({tag, "_rvalid"},  bus.RVALID,  0);
    check({tag, "_rdata"},   bus.RDATA,   0);
    check({tag, "_rlast"},   bus.RLAST,   0);
    check({tag, "_rid"},     bus.RID,     0);
  endtask

  task automatic release_reset(input string tag);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    check({tag, "_awready_pre"}, bus.AWREADY, 0);
    @(negedge ACLK);
    check({tag, "_awready_up"}, bus.AWREADY, 1);
    check({tag, "_arready_up"}, bus.ARREADY, 1);
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    ARESETn = 1'b0;
    bus.AWVALID = 1'b0; bus.AWADDR = '0; bus.AWID = '0;
    bus.WVALID  = 1'b0; bus.WDATA  = '0; bus.WLAST = 1'b0;
    bus.BREADY  = 1'b1;
    bus.ARVALID = 1'b0; bus.ARADDR = '0; bus.ARID = '0;
    bus.RREADY  = 1'b1;

    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values and ready rise after release.
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs("rst0");
    release_reset("rst0");

    // Two-beat in-range write to words 2,3.
    wbeats[0] = 32'hA5A5_0001; wbeats[1] = 32'hA5A5_0002;
    do_write(32'h8, 4'd3, 2, 2'b00);
    drain("wr8");

    // Read back from 0x8: two written words then untouched zeros.
    rexp[0] = 32'hA5A5_0001; rexp[1] = 32'hA5A5_0002; rexp[2] = '0; rexp[3] = '0;
    do_read(32'h8, 4'd5);
    drain("rd8");

    // Burst straddling the top of memory: second beat decodes out of range.
    wbeats[0] = 32'h1111_1111; wbeats[1] = 32'h2222_2222;
    do_write(32'h3C, 4'd1, 2, 2'b11);
    drain("wr3c");
    rexp[0] = '0; rexp[1] = 32'h1111_1111; rexp[2] = '0; rexp[3] = '0;
    do_read(32'h38, 4'd2);
    drain("rd38");

    // Misaligned write with B held off: response must wait stably.
    bus.BREADY = 1'b0;
    wbeats[0] = 32'hDEAD_BEEF;
    do_write(32'h6, 4'd7, 1, 2'b10);
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("bhold_bvalid", bus.BVALID, 1);
      check("bhold_bresp", bus.BRESP, 2'b10);
      check("bhold_bid", bus.BID, 4'd7);
      check("bhold_awready", bus.AWREADY, 0);
    end
    @(posedge ACLK); #1;
    bus.BREADY = 1'b1;
    drain("wr6");
    rexp[0] = '0; rexp[1] = 32'hA5A5_0001; rexp[2] = 32'hA5A5_0002; rexp[3] = '0;
    do_read(32'h4, 4'd0);
    drain("rd4");

    // Read from 0x0 with RREADY toggling; write word 1 while its beat stalls.
    rexp[0] = '0; rexp[1] = '0; rexp[2] = 32'hA5A5_0001; rexp[3] = 32'hA5A5_0002;
    push_read(4'd9);
    exp_b.push_back('{resp: 2'b00, id: 4'd4});
    @(posedge ACLK); #1;
    bus.RREADY = 1'b0;
    bus.ARVALID = 1'b1; bus.ARADDR = 32'h0; bus.ARID = 4'd9;
    bus.AWVALID = 1'b1; bus.AWADDR = 32'h4; bus.AWID = 4'd4;
    @(posedge ACLK); #1;
    bus.ARVALID = 1'b0; bus.AWVALID = 1'b0; bus.RREADY = 1'b1;
    @(posedge ACLK); #1;
    bus.RREADY = 1'b0;
    bus.WVALID = 1'b1; bus.WDATA = 32'hCAFE_0001; bus.WLAST = 1'b1;
    @(posedge ACLK); #1;
    bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.RREADY = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      @(posedge ACLK); #1;
      bus.RREADY = ~bus.RREADY;
    end
    bus.RREADY = 1'b1;
    drain("rdtoggle");
    rexp[0] = 32'hCAFE_0001; rexp[1] = 32'hA5A5_0001; rexp[2] = 32'hA5A5_0002; rexp[3] = '0;
    do_read(32'h4, 4'd6);
    drain("rd4b");

    // Reset in the middle of a write burst: no response, memory cleared.
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b1; bus.AWADDR = 32'h10; bus.AWID = 4'd2;
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
    bus.WVALID = 1'b1; bus.WDATA = 32'h0000_0055; bus.WLAST = 1'b0;
    @(posedge ACLK); #2;
    ARESETn = 1'b0;
    bus.WVALID = 1'b0;
    #1;
    check_reset_outputs("rst1");
    repeat (2) @(posedge ACLK);
    release_reset("rst1");
    rexp[0] = '0; rexp[1] = '0; rexp[2] = '0; rexp[3] = '0;
    do_read(32'h8, 4'd3);
    drain("rdclr8");
    do_read(32'h10, 4'd8);
    drain("rdclr10");

    repeat (3) @(posedge ACLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
